fp_normalize: RTL and testbench

FP_NORMALIZE -- requirements
Module: fp_normalize

---
 rtl/fp_normalize.sv | 137 +++++++++++++
 tb/tb_fp_normalize.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fp_normalize.sv
// Post-add floating-point normalizer: shifts an unnormalized significand one
// bit per cycle until the hidden bit lands at MWIDTH-1, then classifies it.
module fp_normalize #(
  parameter  int WIDTH  = 8,
  parameter  int MWIDTH = 24,
  localparam int LSW    = $clog2(MWIDTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_exp,
  input  logic [MWIDTH:0]   in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_exp,
  output logic [MWIDTH-1:0] out_mant,
  output logic              out_sticky,
  output logic [LSW-1:0]    out_lshift,
  output logic              out_zero,
  output logic              out_denorm,
  output logic              out_overflow
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [WIDTH:0] EXP_ONE = (WIDTH + 1)'(1);
  localparam logic [WIDTH:0] EXP_MAX = {1'b0, {WIDTH{1'b1}}};

  state_t            state_q;
  logic [WIDTH:0]    exp_q;
  logic [MWIDTH:0]   mant_q;
  logic [WIDTH-1:0]  out_exp_q;
  logic [MWIDTH-1:0] out_mant_q;
  logic [LSW-1:0]    lshift_q;
  logic              sticky_q;
  logic              zero_q;
  logic              denorm_q;
  logic              ovf_q;

  logic           is_zero;
  logic           is_carry;
  logic           is_norm;
  logic           is_floor;
  logic [WIDTH:0] exp_inc;
  logic [WIDTH:0] exp_dec;

  // A set hidden bit with exponent 0 is treated as a floor case too, so the
  // exponent never has to decrement below zero.
  always_comb begin
    is_zero  = (mant_q == '0);
    is_carry = mant_q[MWIDTH];
    is_norm  = mant_q[MWIDTH-1] && (exp_q >= EXP_ONE);
    is_floor = (exp_q <= EXP_ONE) && (!mant_q[MWIDTH-1] || exp_q == '0);
    exp_inc  = exp_q + EXP_ONE;
    exp_dec  = exp_q - EXP_ONE;
  end

  // NOTE: all state is updated with non-blocking assignments so every branch
  // below sees the values from before this edge, never a half-updated mix.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      exp_q      <= '0;
      mant_q     <= '0;
      out_exp_q  <= '0;
      out_mant_q <= '0;
      lshift_q   <= '0;
      sticky_q   <= 1'b0;
      zero_q     <= 1'b0;
      denorm_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            exp_q    <= {1'b0, in_exp};
            mant_q   <= in_mant;
            lshift_q <= '0;
            sticky_q <= 1'b0;
            zero_q   <= 1'b0;
            denorm_q <= 1'b0;
            ovf_q    <= 1'b0;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          if (is_zero) begin
            zero_q     <= 1'b1;
            out_exp_q  <= '0;
            out_mant_q <= '0;
            state_q    <= DONE;
          end else if (is_carry) begin
            sticky_q <= mant_q[0];
            if (exp_inc >= EXP_MAX) begin
              ovf_q      <= 1'b1;
              out_exp_q  <= '1;
              out_mant_q <= '0;
            end else begin
              out_exp_q  <= exp_inc[WIDTH-1:0];
              out_mant_q <= mant_q[MWIDTH:1];
            end
            state_q <= DONE;
          end else if (is_norm) begin
            out_exp_q  <= exp_q[WIDTH-1:0];
            out_mant_q <= mant_q[MWIDTH-1:0];
            state_q    <= DONE;
          end else if (is_floor) begin
            denorm_q   <= 1'b1;
            out_exp_q  <= '0;
            out_mant_q <= mant_q[MWIDTH-1:0];
            state_q    <= DONE;
          end else begin
            mant_q   <= {mant_q[MWIDTH-1:0], 1'b0};
            exp_q    <= exp_dec;
            lshift_q <= lshift_q + LSW'(1);
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign out_exp      = out_exp_q;
  assign out_mant     = out_mant_q;
  assign out_sticky   = sticky_q;
  assign out_lshift   = lshift_q;
  assign out_zero     = zero_q;
  assign out_denorm   = denorm_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_fp_normalize.sv
// Directed bench for fp_normalize (WIDTH=8, MWIDTH=24) with hand-computed
// expectations; latency is counted in clock edges after the accept edge.
module tb_fp_normalize;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_exp;
  logic [23:0] out_mant;
  logic        out_sticky;
  logic [4:0]  out_lshift;
  logic        out_zero;
  logic        out_denorm;
  logic        out_overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_normalize #(.WIDTH(8), .MWIDTH(24)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_exp(out_exp), .out_mant(out_mant),
    .out_sticky(out_sticky), .out_lshift(out_lshift),
    .out_zero(out_zero), .out_denorm(out_denorm),
    .out_overflow(out_overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one operand, waits for the result, returns edges from accept
  // until the edge at which out_valid is first seen high.
  task automatic send(input logic [24:0] mant, input logic [7:0] exp, output int edges);
    int n;
    in_mant  = mant;
    in_exp   = exp;
    in_valid = 1'b1;
    check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    edges = n + 1;
  endtask

  task automatic expect_result(input string tag, input int edges, input int exp_edges,
                               input logic [7:0] e, input logic [23:0] m,
                               input logic s, input logic [4:0] ls, input logic [2:0] flags);
    check({tag, "_latency"}, edges, exp_edges);
    check({tag, "_exp"}, {24'b0, out_exp}, {24'b0, e});
    check({tag, "_mant"}, {8'b0, out_mant}, {8'b0, m});
    check({tag, "_sticky"}, {31'b0, out_sticky}, {31'b0, s});
    check({tag, "_lshift"}, {27'b0, out_lshift}, {27'b0, ls});
    check({tag, "_flags_zdo"}, {29'b0, out_zero, out_denorm, out_overflow}, {29'b0, flags});
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("consumed_out_valid", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    int e;
    int seen;
    logic [23:0] held_mant;
    logic [7:0]  held_exp;

    reset = 1'b1; in_valid = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_exp_mant", {out_exp, out_mant}, 32'd0);
    check("rst_misc", {26'b0, out_sticky, out_zero, out_denorm, out_overflow, 2'b0} | {27'b0, out_lshift}, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // Already normalized.
    send(25'h0800000, 8'd127, e);
    expect_result("norm", e, 2, 8'd127, 24'h800000, 1'b0, 5'd0, 3'b000);
    consume();

    // Carry with a set dropped bit, then with a clear one.
    send(25'h1000001, 8'd127, e);
    expect_result("carry_st1", e, 2, 8'd128, 24'h800000, 1'b1, 5'd0, 3'b000);
    consume();
    send(25'h1000000, 8'd127, e);
    expect_result("carry_st0", e, 2, 8'd128, 24'h800000, 1'b0, 5'd0, 3'b000);
    consume();

    // Fifteen left shifts.
    send(25'h0000100, 8'd127, e);
    expect_result("lshift15", e, 17, 8'd112, 24'h800000, 1'b0, 5'd15, 3'b000);
    consume();

    // Hits the exponent floor after two shifts.
    send(25'h0000001, 8'd3, e);
    expect_result("denorm", e, 4, 8'd0, 24'h000004, 1'b0, 5'd2, 3'b010);
    consume();

    // Exponent already at 1 with the hidden bit clear.
    send(25'h0400000, 8'd1, e);
    expect_result("floor_now", e, 2, 8'd0, 24'h400000, 1'b0, 5'd0, 3'b010);
    consume();

    // Zero significand.
    send(25'h0000000, 8'd50, e);
    expect_result("zero", e, 2, 8'd0, 24'h000000, 1'b0, 5'd0, 3'b100);
    consume();

    // Carry into the all-ones exponent.
    send(25'h1000000, 8'd254, e);
    expect_result("overflow", e, 2, 8'hFF, 24'h000000, 1'b0, 5'd0, 3'b001);
    consume();

    // Backpressure: result held for 5 cycles, new operand refused meanwhile.
    send(25'h0C00000, 8'd10, e);
    expect_result("hold", e, 2, 8'd10, 24'hC00000, 1'b0, 5'd0, 3'b000);
    held_mant = out_mant;
    held_exp  = out_exp;
    in_valid = 1'b1; in_mant = 25'h0800000; in_exp = 8'd99;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      check("hold_data", {out_exp, out_mant}, {held_exp, held_mant});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("no_accept_on_consume", {30'b0, in_ready, out_valid}, 32'd2);
    in_valid = 1'b0;

    // Reset mid-shift discards the operand.
    send_no_wait(25'h0000100, 8'd127);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_lshift", {27'b0, out_lshift}, 32'd0);
    @(negedge clk); @(negedge clk); reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst_no_valid", seen, 0);

    // Single left shift after the reset.
    send(25'h0400000, 8'd5, e);
    expect_result("lshift1", e, 3, 8'd4, 24'h800000, 1'b0, 5'd1, 3'b000);
    consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic send_no_wait(input logic [24:0] mant, input logic [7:0] exp);
    in_mant  = mant;
    in_exp   = exp;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

endmodule
